priority_encoder_reg: RTL
=========================

PRIORITY_ENCODER_REG -- requirements
Module: priority_encoder_reg

Interface
- REQ-001 Parameter WIDTH, default 8, number of request lines; legal values are powers of two from 2 to 64.
- REQ-002 Parameter DROP_W, default 8, width of the dropped-request counter.
- REQ-003 Derived constant CODE_W = log2(WIDTH); it is not user-overridable.
- REQ-004 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
- REQ-005 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
- REQ-006 Port req, input, WIDTH bits: request lines; bit i means request i is active.
- REQ-007 Port mode, input, 2 bits: 0 = fixed MSB-first, 1 = fixed LSB-first, 2 = round-robin, 3 = reserved (behaves as 0).
- REQ-008 Port out_ready, input, 1 bit: the consumer accepts out_code in this cycle.
- REQ-009 Port out_valid, output, 1 bit: out_code, out_multi and out_vec hold a captured result.
- REQ-010 Port out_code, output, CODE_W bits: binary index of the selected request.
- REQ-011 Port out_multi, output, 1 bit: more than one req bit was set at capture.
- REQ-012 Port out_vec, output, WIDTH bits: copy of req at capture.
- REQ-013 Port drop_cnt, output, DROP_W bits: saturating count of cycles in which a request was discarded.

Function
- REQ-014 The block SHALL have two states: EMPTY (out_valid=0) and FULL (out_valid=1).
- REQ-015 Define "load" as (req != 0) AND (state EMPTY OR (out_valid AND out_ready)).
- REQ-016 On load, the block SHALL register out_code, out_multi and out_vec from the current req and mode, and enter FULL on the next edge (1-cycle latency).
- REQ-017 In state FULL, if out_ready=1 and req=0, the block SHALL return to EMPTY on the next edge.
- REQ-018 In state FULL, if out_ready=0, all outputs SHALL hold unchanged regardless of req or mode.
- REQ-019 When out_valid and out_ready are both high and req != 0, the block SHALL accept and reload in the same edge, with no bubble cycle.
- REQ-020 In mode 0 and mode 3, out_code SHALL be the highest set index of req.
- REQ-021 In mode 1, out_code SHALL be the lowest set index of req.
- REQ-022 In mode 2, out_code SHALL be the first set index at or above pointer rr_ptr, searching upward with wrap from WIDTH-1 to 0.
- REQ-023 Pointer rr_ptr (CODE_W bits) SHALL update to (out_code+1) mod WIDTH only on a mode-2 load; loads in other modes leave it unchanged.
- REQ-024 out_multi SHALL be 1 when popcount(req) >= 2 at the load cycle, else 0.
- REQ-025 drop_cnt SHALL increment by 1 in each cycle where req != 0, state is FULL and out_ready=0.
- REQ-026 drop_cnt SHALL saturate at 2^DROP_W-1 and never wrap.
- REQ-027 A mode change SHALL take effect in the next load cycle; a held result SHALL NOT be re-encoded.
- REQ-028 A single-bit req SHALL give the same out_code in all modes.

Reset
- REQ-029 While rst_n=0: out_valid=0, out_code=0, out_multi=0, out_vec=0, drop_cnt=0, rr_ptr=0, state EMPTY.
- REQ-030 Reset SHALL take effect immediately without a clock edge, including while in FULL; a pending result is discarded and is not counted as a drop.
- REQ-031 After rst_n deasserts, the first rising edge SHALL already be able to perform a load.

Verification (WIDTH=8, DROP_W=8)
- REQ-032 One-hot sweep: req=0x01, 0x02, 0x04 ... 0x80 in mode 0 with out_ready=1 -> out_code 0..7 one cycle later, out_multi=0, no bubbles between codes.
- REQ-033 Priority: req=0x12 -> out_code=4 in mode 0, out_code=1 in mode 1, out_multi=1 and out_vec=0x12 in both.
- REQ-034 Round-robin: req=0x81 held, mode 2, out_ready=1 -> out_code sequence 0,7,0,7; rr_ptr sequence 1,0,1,0.
- REQ-035 Backpressure: load 0x04, then out_ready=0 for 300 cycles with req=0x01 -> out_code stays 2, drop_cnt saturates at 255; then out_ready=1 -> next out_code=0.
- REQ-036 Reset mid-operation: in FULL, pulse rst_n low between clock edges -> all outputs 0 immediately; first edge after release with req=0x08 -> out_valid=1 and out_code=3.
- REQ-037 Idle: req=0 with out_ready=1 -> out_valid falls one cycle after the last accept, and drop_cnt does not change.

Source files
------------

// File: rtl/priority_encoder_reg.sv
// priority_encoder_reg
//   Registered priority encoder with a one-entry valid/ready output stage.
//   Each accepted request vector is encoded according to mode (MSB-first,
//   LSB-first or round-robin) and held until the consumer takes it. A
//   non-zero request that cannot be captured because the held result is
//   stalled is counted in a saturating drop counter.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   req        in   [WIDTH]   request lines, bit i = request i active
//   mode       in   [2]       0/3 MSB-first, 1 LSB-first, 2 round-robin
//   out_ready  in   consumer takes the held result this cycle
//   out_valid  out  a captured result is held
//   out_code   out  [CODE_W]  index of the selected request
//   out_multi  out  more than one request bit was set at capture
//   out_vec    out  [WIDTH]   request vector seen at capture
//   drop_cnt   out  [DROP_W]  saturating count of stalled-request cycles
module priority_encoder_reg #(
  parameter  int WIDTH  = 8,
  parameter  int DROP_W = 8,
  localparam int CODE_W = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  req,
  input  logic [1:0]        mode,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [CODE_W-1:0] out_code,
  output logic              out_multi,
  output logic [WIDTH-1:0]  out_vec,
  output logic [DROP_W-1:0] drop_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  function automatic logic [CODE_W-1:0] enc_msb(input logic [WIDTH-1:0] r);
    logic [CODE_W-1:0] code;
    code = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (r[i]) code = i[CODE_W-1:0];
    end
    return code;
  endfunction

  function automatic logic [CODE_W-1:0] enc_lsb(input logic [WIDTH-1:0] r);
    logic [CODE_W-1:0] code;
    code = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (r[i]) code = i[CODE_W-1:0];
    end
    return code;
  endfunction

  // Walk the offsets from the far end down so the nearest set bit at or
  // above ptr is the last one written; the CODE_W-bit add wraps for free.
  function automatic logic [CODE_W-1:0] enc_rr(input logic [WIDTH-1:0]  r,
                                               input logic [CODE_W-1:0] ptr);
    logic [CODE_W-1:0] code;
    logic [CODE_W-1:0] idx;
    code = '0;
    for (int k = WIDTH - 1; k >= 0; k--) begin
      idx = ptr + k[CODE_W-1:0];
      if (r[idx]) code = idx;
    end
    return code;
  endfunction

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] c);
    return (c == {DROP_W{1'b1}}) ? c : c + DROP_W'(1);
  endfunction

  state_t              state_p1;
  logic [CODE_W-1:0]   code_p1;
  logic                multi_p1;
  logic [WIDTH-1:0]    vec_p1;
  logic [CODE_W-1:0]   rr_ptr_p1;
  logic [DROP_W-1:0]   drop_p1;

  state_t              state_p0;
  logic [CODE_W-1:0]   code_p0;
  logic                multi_p0;
  logic [WIDTH-1:0]    vec_p0;
  logic [CODE_W-1:0]   rr_ptr_p0;
  logic [DROP_W-1:0]   drop_p0;

  logic                req_any_p0;
  logic                accept_p0;
  logic                load_p0;
  logic [CODE_W-1:0]   sel_code_p0;

  // ---- stage 0: encode the live request and decide the next state ----
  always_comb begin
    req_any_p0 = |req;
    accept_p0  = (state_p1 == FULL) && out_ready;
    load_p0    = req_any_p0 && ((state_p1 == EMPTY) || accept_p0);

    case (mode)
      2'd1:    sel_code_p0 = enc_lsb(req);
      2'd2:    sel_code_p0 = enc_rr(req, rr_ptr_p1);
      default: sel_code_p0 = enc_msb(req);
    endcase

    state_p0  = state_p1;
    code_p0   = code_p1;
    multi_p0  = multi_p1;
    vec_p0    = vec_p1;
    rr_ptr_p0 = rr_ptr_p1;
    drop_p0   = drop_p1;

    if (load_p0) begin
      state_p0 = FULL;
      code_p0  = sel_code_p0;
      multi_p0 = |(req & (req - WIDTH'(1)));
      vec_p0   = req;
      if (mode == 2'd2) rr_ptr_p0 = sel_code_p0 + CODE_W'(1);
    end else if (accept_p0) begin
      state_p0 = EMPTY;
    end

    if (req_any_p0 && (state_p1 == FULL) && !out_ready) begin
      drop_p0 = sat_inc(drop_p1);
    end
  end

  // ---- stage 1: registered result, pointer and drop counter ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1  <= EMPTY;
      code_p1   <= '0;
      multi_p1  <= 1'b0;
      vec_p1    <= '0;
      rr_ptr_p1 <= '0;
      drop_p1   <= '0;
    end else begin
      state_p1  <= state_p0;
      code_p1   <= code_p0;
      multi_p1  <= multi_p0;
      vec_p1    <= vec_p0;
      rr_ptr_p1 <= rr_ptr_p0;
      drop_p1   <= drop_p0;
    end
  end

  assign out_valid = (state_p1 == FULL);
  assign out_code  = code_p1;
  assign out_multi = multi_p1;
  assign out_vec   = vec_p1;
  assign drop_cnt  = drop_p1;

endmodule
